// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, config field layout and arbiter state encoding
package uart_pkg;

  localparam int DATA_W = 9;
  localparam int CFG_W  = 27;

  // uart_tx config word layout
  localparam int CFG_PRESCALE_LSB  = 0;
  localparam int CFG_PRESCALE_W    = 16;
  localparam int CFG_PARITY_LSB    = 16;
  localparam int CFG_PARITY_W      = 3;
  localparam int CFG_BYTE_SIZE_LSB = 19;
  localparam int CFG_BYTE_SIZE_W   = 4;
  localparam int CFG_STOP_BITS_BIT = 23;
  localparam int CFG_TX_EN_BIT     = 25;

  typedef enum logic [2:0] {
    PARITY_NONE  = 3'd0,
    PARITY_EVEN  = 3'd1,
    PARITY_ODD   = 3'd2,
    PARITY_MARK  = 3'd3,
    PARITY_SPACE = 3'd4
  } parity_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_HDR  = 2'd2,
    ST_DATA = 2'd3
  } arb_state_e;

  function automatic logic [7:0] header_byte(input logic [7:0] base, input logic [2:0] ch);
    return base + {5'd0, ch};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester, config and uart_tx-facing stream bundle of the arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_CH = 4
);
  import uart_pkg::*;

  logic [DATA_W*NUM_CH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [CFG_W-1:0]         s_axis_config_tdata;
  logic                     s_axis_config_tvalid;
  logic                     s_axis_config_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [CFG_W-1:0]         m_axis_config_tdata;
  logic                     m_axis_config_tvalid;
  logic                     m_axis_config_tready;
  logic [2:0]               grant;
  logic                     grant_valid;
  logic                     trunc_err;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    input  s_axis_config_tdata, s_axis_config_tvalid,
    output s_axis_config_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_config_tdata, m_axis_config_tvalid,
    input  m_axis_config_tready,
    output grant, grant_valid, trunc_err
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    output s_axis_config_tdata, s_axis_config_tvalid,
    input  s_axis_config_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_config_tdata, m_axis_config_tvalid,
    output m_axis_config_tready,
    input  grant, grant_valid, trunc_err
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational rotate-priority encoder: first request at or above ptr, with wrap
module uart_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request is written last and wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin scheduler sharing one uart_tx among NUM_CH streams
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BASE = 8'hF0,
  parameter int         MAX_PKT_LEN = 256
) (
  input logic              aclk,
  input logic              areset,
  uart_tx_arbiter_if.slave bus
);

  localparam int          IDX_W     = $clog2(NUM_CH);
  localparam logic [15:0] PKT_LIMIT = 16'(MAX_PKT_LEN);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]      beat_q, beat_d;
  logic             trunc_q, trunc_d;

  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic              data_hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_split
    assign ch_data[g] = bus.s_axis_tdata[DATA_W*g +: DATA_W];
  end

  uart_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req    (bus.s_axis_tvalid),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      trunc_q  <= trunc_d;
    end
  end

  always_comb begin
    state_d                  = state_q;
    grant_d                  = grant_q;
    rr_ptr_d                 = rr_ptr_q;
    beat_d                   = beat_q;
    trunc_d                  = trunc_q;
    data_hs                  = 1'b0;
    bus.s_axis_tready        = '0;
    bus.s_axis_config_tready = 1'b0;
    bus.m_axis_tdata         = '0;
    bus.m_axis_tvalid        = 1'b0;
    bus.m_axis_config_tdata  = '0;
    bus.m_axis_config_tvalid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_axis_config_tvalid) begin
          state_d = ST_CFG;
        end else if (any_req) begin
          grant_d = winner;
          beat_d  = '0;
          state_d = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
        end
      end
      ST_CFG: begin
        bus.m_axis_config_tdata  = bus.s_axis_config_tdata;
        bus.m_axis_config_tvalid = 1'b1;
        bus.s_axis_config_tready = bus.m_axis_config_tready;
        if (bus.s_axis_config_tvalid && bus.m_axis_config_tready) state_d = ST_IDLE;
      end
      ST_HDR: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tdata  = {1'b0, header_byte(HEADER_BASE, 3'(grant_q))};
        if (bus.m_axis_tready) state_d = ST_DATA;
      end
      ST_DATA: begin
        bus.m_axis_tdata           = ch_data[grant_q];
        bus.m_axis_tvalid          = bus.s_axis_tvalid[grant_q];
        bus.s_axis_tready[grant_q] = bus.m_axis_tready;
        data_hs = bus.s_axis_tvalid[grant_q] && bus.m_axis_tready;
        if (data_hs) begin
          beat_d = beat_q + 16'd1;
          // Hitting the limit without tlast closes the packet; the rest re-arbitrates.
          if (bus.s_axis_tlast[grant_q] || beat_d == PKT_LIMIT) begin
            rr_ptr_d = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
            if (!bus.s_axis_tlast[grant_q]) trunc_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.grant       = 3'(grant_q);
  assign bus.grant_valid = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign bus.trunc_err   = trunc_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin scheduler that shares one `uart_tx` instance among `NUM_CH` AXI-Stream requesters and sequences its dynamic configuration. It sits directly upstream of `uart_tx`: its data master drives `s_axis_tdata/tvalid/tready`, and its config master drives `s_axis_config_*`. Each granted packet is optionally prefixed with a channel-ID header byte. Config words are forwarded only between packets, so a reconfiguration never splits a packet.

## Interface

Parameters:
- `NUM_CH`, 4: number of requesters, 2..8.
- `HEADER_EN`, 1: 1 = emit a header byte before each packet.
- `HEADER_BASE`, 8'hF0: header byte value = `HEADER_BASE + channel index`, mod 256.
- `MAX_PKT_LEN`, 256: beat limit per packet, 1..65535.

Ports:
- `aclk` in 1: clock; one clock domain.
- `areset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 9*NUM_CH: channel i occupies bits [9i+8:9i].
- `s_axis_tvalid` in NUM_CH: per-channel valid.
- `s_axis_tlast` in NUM_CH: per-channel end of packet.
- `s_axis_tready` out NUM_CH: per-channel ready.
- `s_axis_config_tdata` in 27: config word, uart_tx format.
- `s_axis_config_tvalid` in 1: config valid.
- `s_axis_config_tready` out 1: config ready.
- `m_axis_tdata` out 9: data to uart_tx.
- `m_axis_tvalid` out 1: data valid.
- `m_axis_tready` in 1: data ready.
- `m_axis_config_tdata` out 27: config to uart_tx.
- `m_axis_config_tvalid` out 1: config valid.
- `m_axis_config_tready` in 1: config ready.
- `grant` out 3: index of the channel owning the link.
- `grant_valid` out 1: a packet is in progress (states HDR and DATA).
- `trunc_err` out 1: sticky; cleared only by reset.

## Operation

- Reset values:
  - All outputs are 0.
  - `rr_ptr` = 0, beat counter = 0, state = IDLE.
- State machine: IDLE, CFG, HDR, DATA.
- IDLE:
  - If `s_axis_config_tvalid`, go to CFG. Config has priority over data.
  - Otherwise, if any `s_axis_tvalid`, latch the round-robin winner into `grant` and clear the beat counter. The winner is the first valid channel at or after `rr_ptr`, searching upward with wrap.
  - Then go to HDR if `HEADER_EN`, else DATA.
  - All `s_axis_tready` bits are 0 in IDLE.
- CFG:
  - `m_axis_config_tdata` = `s_axis_config_tdata`.
  - `m_axis_config_tvalid` = 1.
  - `s_axis_config_tready` = `m_axis_config_tready`.
  - On handshake, go to IDLE.
  - uart_tx accepts config only while idle; the arbiter just waits.
- HDR:
  - `m_axis_tvalid` = 1, `m_axis_tdata` = {1'b0, HEADER_BASE + grant}.
  - On handshake, go to DATA.
  - The header does not count toward `MAX_PKT_LEN`.
- DATA:
  - Zero-latency combinational pass-through of channel `grant`: `m_axis_tdata`, `m_axis_tvalid`, and `s_axis_tready[grant]` = `m_axis_tready`.
  - Other channels' ready is 0.
  - Each handshake increments the beat counter (16 bit).
  - On a handshake with `tlast`, or on the `MAX_PKT_LEN`-th beat: set `rr_ptr` = (grant+1) mod NUM_CH and go to IDLE.
  - If the packet ends by the limit without `tlast`, set `trunc_err`. The remaining beats of that packet re-arbitrate as a new packet.
- `s_axis_config_tready` is 0 outside CFG.

## Timing

- Grant decision takes 1 cycle in IDLE.
- First header beat is offered the cycle after grant.
- Packet-to-packet gap is at least 1 IDLE cycle.
- A config arriving mid-packet waits for that packet's end. It is forwarded in the cycle after IDLE sees it.
- Simultaneous config and data valid in IDLE: config wins.
- All channels valid: grants rotate 0,1,2,3,0…
- A single channel valid: it is regranted each packet, independent of `rr_ptr`.
- A requester dropping `tvalid` mid-packet stalls the link. The grant is held; there is no timeout.
- `areset` mid-packet:
  - Next cycle, all outputs return to their reset values and the in-flight packet is abandoned.
  - `uart_tx` shares this reset, so its FIFO clears consistently.

## Structure

- Shared package `uart_pkg` holds:
  - State encoding.
  - Config field offsets: prescaler [15:0], parity [18:16], byte_size [22:19], stop_bits [23], tx_en [25].
  - Parity codes 0..4.
  - Data width 9.
- One sub-module, `uart_rr_arbiter`: combinational rotate-priority encoder. It takes `req[NUM_CH]` and `ptr` and outputs `winner`, `any`.

## Test plan

- Ch0 and ch2 each send a 3-beat packet, both valid at once, after reset → output F0,a0,a1,a2,F2,c0,c1,c2, and `grant` sequence 0 then 2.
- All 4 channels stream 1-beat packets continuously → headers F0,F1,F2,F3,F0; no channel is starved.
- Config 27'h0000068 is raised mid-packet on ch1 → it is forwarded only after ch1's `tlast` handshake and before the next header.
- `MAX_PKT_LEN`=4, ch3 sends 6 beats with no `tlast` → beat 4 ends the packet and `trunc_err`=1; the remaining 2 beats follow a new F3 header.
- `m_axis_tready` toggles 1/0 every cycle → no beat is dropped or duplicated; the byte order matches the input.
- `areset` pulsed during beat 2 of a 5-beat packet → all outputs 0 the next cycle; the following packet is granted starting from ch0.
